// File: rtl/bcd_share_scan_ctrl_pkg.sv
// Shared types and constants for the BCD share/scan controller.
// Holds the FSM state encoding, BCD limits and a width helper.
package bcd_share_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int BCD_WIDTH = 8;
   localparam int BCD_MAX_DEC = 99;
   localparam logic [BCD_WIDTH-1:0] BCD_SAT = 8'h99;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/bcd_share_scan_ctrl_if.sv
// Request/ack bundle between the game logic and the BCD share controller.
// Ports: req, bin_flat (requester -> ctrl); ack, busy, ovf (ctrl -> requester).
interface bcd_share_scan_ctrl_if #(
   parameter int NUM_SRC = 3,
   parameter int BIN_WIDTH = 8
);

   logic [NUM_SRC-1:0]           req;
   logic [NUM_SRC*BIN_WIDTH-1:0] bin_flat;
   logic [NUM_SRC-1:0]           ack;
   logic                         busy;
   logic [NUM_SRC-1:0]           ovf;

   modport master (
      output req,
      output bin_flat,
      input  ack,
      input  busy,
      input  ovf
   );

   modport slave (
      input  req,
      input  bin_flat,
      output ack,
      output busy,
      output ovf
   );

endinterface

// File: rtl/bcd_share_scan_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first set req bit after last_grant.
// Ports: req, last_grant in; grant index and valid out (combinational).
module bcd_share_scan_ctrl_rr_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int IDX_W = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant,
   output logic               valid
);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest candidate down to the nearest so the
   // nearest set bit after last_grant is written last and wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         cand = IDX_W'((int'(last_grant) + k) % NUM_SRC);
         if (req[cand]) begin
            grant = cand;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_share_scan_ctrl.sv
// Shares one binary-to-BCD converter among NUM_SRC requesters, caches
// results and scans all digits onto a common-anode 7-segment bus.
// Ports: clk, rst_n; bus (req/bin_flat/ack/busy/ovf); conv_bin/conv_bcd
// to the external converter; an_n/digit to the display driver.
module bcd_share_scan_ctrl
   import bcd_share_scan_ctrl_pkg::*;
#(
   parameter int NUM_SRC   = 3,
   parameter int BIN_WIDTH = 8,
   parameter int SCAN_DIV  = 50000,
   parameter int LZ_BLANK  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   bcd_share_scan_ctrl_if.slave   bus,
   output logic [BIN_WIDTH-1:0]   conv_bin,
   input  logic [BCD_WIDTH-1:0]   conv_bcd,
   output logic [2*NUM_SRC-1:0]   an_n,
   output logic [3:0]             digit
);

   localparam int IDX_W   = clog2_min1(NUM_SRC);
   localparam int NUM_DIG = 2 * NUM_SRC;
   localparam int DIG_W   = clog2_min1(NUM_DIG);
   localparam int PRE_W   = clog2_min1(SCAN_DIV);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       g_q, g_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [BIN_WIDTH-1:0]   conv_bin_q, conv_bin_d;
   logic [NUM_SRC-1:0]     ovf_q, ovf_d;
   logic [BCD_WIDTH-1:0]   cache_q [NUM_SRC];
   logic [BCD_WIDTH-1:0]   cache_d [NUM_SRC];
   logic [PRE_W-1:0]       presc_q, presc_d;
   logic [DIG_W-1:0]       dig_q, dig_d;
   logic [NUM_SRC-1:0]     ack_c;

   logic [IDX_W-1:0]       arb_grant;
   logic                   arb_valid;

   bcd_share_scan_ctrl_rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req        (bus.req),
      .last_grant (last_q),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   // Conversion FSM
   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      last_d     = last_q;
      conv_bin_d = conv_bin_q;
      ovf_d      = ovf_q;
      cache_d    = cache_q;
      ack_c      = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               g_d        = arb_grant;
               conv_bin_d = bus.bin_flat[arb_grant*BIN_WIDTH +: BIN_WIDTH];
               state_d    = ST_CONV;
            end
         end
         ST_CONV: begin
            // Two BCD digits cannot hold more than 99: saturate and flag.
            if (conv_bin_q > BIN_WIDTH'(BCD_MAX_DEC)) begin
               cache_d[g_q] = BCD_SAT;
               ovf_d[g_q]   = 1'b1;
            end else begin
               cache_d[g_q] = conv_bcd;
               ovf_d[g_q]   = 1'b0;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            ack_c[g_q] = 1'b1;
            last_d     = g_q;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Scan prescaler and digit index
   always_comb begin
      presc_d = presc_q + PRE_W'(1);
      dig_d   = dig_q;
      if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
         presc_d = '0;
         if (dig_q == DIG_W'(NUM_DIG - 1)) begin
            dig_d = '0;
         end else begin
            dig_d = dig_q + DIG_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         g_q        <= '0;
         last_q     <= IDX_W'(NUM_SRC - 1);
         conv_bin_q <= '0;
         ovf_q      <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            cache_q[i] <= '0;
         end
         presc_q    <= '0;
         dig_q      <= '0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         last_q     <= last_d;
         conv_bin_q <= conv_bin_d;
         ovf_q      <= ovf_d;
         cache_q    <= cache_d;
         presc_q    <= presc_d;
         dig_q      <= dig_d;
      end
   end

   // Display decode, straight from registers
   logic [IDX_W-1:0]     scan_src;
   logic [BCD_WIDTH-1:0] scan_ent;
   logic [3:0]           scan_nib;

   always_comb begin
      scan_src = IDX_W'(dig_q >> 1);
      scan_ent = cache_q[scan_src];
      scan_nib = dig_q[0] ? scan_ent[7:4] : scan_ent[3:0];
      digit    = scan_nib;
      an_n     = ~(NUM_DIG'(1) << dig_q);
      if ((LZ_BLANK != 0) && dig_q[0] && (scan_nib == 4'd0)) begin
         an_n = '1;
      end
   end

   assign conv_bin = conv_bin_q;
   assign bus.ack  = ack_c;
   assign bus.busy = (state_q != ST_IDLE);
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_share_scan_ctrl.sv
// Randomised and directed bench for bcd_share_scan_ctrl with a
// transaction-level model of arbitration, caching and the digit scan.
module tb_bcd_share_scan_ctrl;

   localparam int NS = 3;
   localparam int BW = 8;
   localparam int SD = 4;
   localparam int LZ = 1;
   localparam int ND = 2 * NS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [BW-1:0]  conv_bin;
   logic [7:0]     conv_bcd;
   logic [ND-1:0]  an_n;
   logic [3:0]     digit;

   bcd_share_scan_ctrl_if #(.NUM_SRC(NS), .BIN_WIDTH(BW)) bus ();

   // External converter (only meaningful below 100)
   assign conv_bcd = {4'((conv_bin % 100) / 10), 4'(conv_bin % 10)};

   bcd_share_scan_ctrl #(
      .NUM_SRC   (NS),
      .BIN_WIDTH (BW),
      .SCAN_DIV  (SD),
      .LZ_BLANK  (LZ)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .conv_bin (conv_bin),
      .conv_bcd (conv_bcd),
      .an_n     (an_n),
      .digit    (digit)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: a transaction is "cycles left until it retires".
   int         m_left, m_g, m_last, m_t;
   logic [7:0] m_conv;
   logic [7:0] m_cache [NS];
   logic [NS-1:0] m_ovf;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         m_left = 0; m_g = 0; m_last = NS - 1; m_t = 0;
         m_conv = '0; m_ovf = '0;
         for (int i = 0; i < NS; i++) m_cache[i] = 8'h00;
      end else begin
         m_t++;
         case (m_left)
            2: begin
               if (m_conv > 99) begin
                  m_cache[m_g] = 8'h99; m_ovf[m_g] = 1'b1;
               end else begin
                  m_cache[m_g] = to_bcd(int'(m_conv)); m_ovf[m_g] = 1'b0;
               end
               m_left = 1;
            end
            1: begin
               m_last = m_g; m_left = 0;
            end
            default: begin
               for (int k = 1; k <= NS; k++) begin
                  int s;
                  s = (m_last + k) % NS;
                  if (bus.req[s]) begin
                     m_g = s;
                     m_conv = bus.bin_flat[s*BW +: BW];
                     m_left = 2;
                     break;
                  end
               end
            end
         endcase
      end
   endtask

   task automatic check_outputs();
      int d;
      logic [7:0] ent;
      logic [3:0] nib;
      logic [ND-1:0] ea;
      d   = (m_t / SD) % ND;
      ent = m_cache[d / 2];
      nib = (d % 2 == 1) ? ent[7:4] : ent[3:0];
      ea  = ~(ND'(1) << d);
      if (LZ != 0 && d % 2 == 1 && nib == 4'd0) ea = '1;
      chk("ack", bus.ack, (m_left == 1) ? (32'd1 << m_g) : 32'd0);
      chk("busy", bus.busy, m_left != 0);
      chk("conv_bin", conv_bin, m_conv);
      chk("ovf", bus.ovf, m_ovf);
      chk("an_n", an_n, ea);
      chk("digit", digit, nib);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wait_ack(input int src, output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         n++;
         if (bus.ack[src]) return;
      end
      chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_scan(input int d);
      for (int i = 0; i < 4 * SD * ND; i++) begin
         if ((m_t / SD) % ND == d) return;
         cycle();
      end
      chk("scan_timeout", 32'd0, 32'd1);
   endtask

   logic [ND-1:0] tbl [ND];
   int n, cnt, seen;
   int order [6];
   int gap [6];
   logic [NS-1:0] acked;

   initial begin
      tbl[0] = 6'b111110; tbl[1] = 6'b111111; tbl[2] = 6'b111011;
      tbl[3] = 6'b111111; tbl[4] = 6'b101111; tbl[5] = 6'b111111;
      rst_n = 1'b0;
      bus.req = '0;
      bus.bin_flat = '0;
      @(negedge clk);
      cycle();
      cycle();
      rst_n = 1'b1;

      // Empty cache: odd digits blanked, 4 cycles per digit
      for (int i = 1; i <= 24; i++) begin
         cycle();
         if (i % 4 == 0) chk("scan_lit", an_n, tbl[(i / 4) % ND]);
      end

      // Single conversion of 42
      bus.bin_flat[0 +: BW] = 8'd42;
      bus.req = 3'b001;
      wait_ack(0, n);
      chk("ack_latency", n, 2);
      bus.req = '0;
      chk("cache0_42", m_cache[0], 8'h42);
      wait_scan(0);
      chk("dig0_lit", digit, 4'd2);
      wait_scan(1);
      chk("dig1_lit", digit, 4'd4);
      chk("an1_lit", an_n, 6'b111101);

      // Three sources held continuously
      bus.bin_flat = {8'd99, 8'd58, 8'd7};
      bus.req = 3'b111;
      cnt = 0; seen = 0;
      for (int i = 0; i < 40 && seen < 6; i++) begin
         cycle();
         cnt++;
         if (bus.ack != 0) begin
            for (int s = 0; s < NS; s++) if (bus.ack[s]) order[seen] = s;
            gap[seen] = cnt;
            cnt = 0;
            seen++;
         end
      end
      bus.req = '0;
      chk("rr_count", seen, 6);
      for (int i = 0; i < 6; i++) chk("rr_order", order[i], (i + 1) % NS);
      for (int i = 1; i < 6; i++) chk("rr_gap", gap[i], 3);
      chk("cache2_99", m_cache[2], 8'h99);
      wait_scan(1);
      chk("blank_tens7", an_n, 6'b111111);

      // Overflow and recovery on source 1
      bus.bin_flat[BW +: BW] = 8'd200;
      bus.req = 3'b010;
      wait_ack(1, n);
      bus.req = '0;
      chk("ovf1_set", bus.ovf[1], 1'b1);
      chk("cache1_sat", m_cache[1], 8'h99);
      bus.bin_flat[BW +: BW] = 8'd5;
      bus.req = 3'b010;
      wait_ack(1, n);
      bus.req = '0;
      cycle();
      chk("ovf1_clr", bus.ovf[1], 1'b0);
      chk("cache1_05", m_cache[1], 8'h05);

      // Reset while converting
      bus.bin_flat[0 +: BW] = 8'd33;
      bus.req = 3'b001;
      cycle();
      chk("in_conv", bus.busy, 1'b1);
      rst_n = 1'b0;
      bus.req = '0;
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("no_ack_rst", bus.ack, 3'b000);
      end
      chk("cache0_rst", m_cache[0], 8'h00);
      bus.bin_flat = {8'd0, 8'd22, 8'd11};
      bus.req = 3'b011;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (bus.ack != 0) break;
      end
      chk("post_rst_grant", bus.ack, 3'b001);
      bus.req = '0;
      cycle();

      // Random traffic
      acked = '0;
      for (int c = 0; c < 3000; c++) begin
         acked = acked | bus.ack;
         for (int s = 0; s < NS; s++) begin
            if (bus.req[s]) begin
               if (acked[s] && $urandom_range(1, 0) == 1) begin
                  bus.req[s] = 1'b0; acked[s] = 1'b0;
               end else if ($urandom_range(499, 0) == 0) begin
                  bus.req[s] = 1'b0; acked[s] = 1'b0;
               end
            end else if ($urandom_range(3, 0) == 0) begin
               bus.bin_flat[s*BW +: BW] = ($urandom_range(3, 0) == 0)
                  ? 8'($urandom_range(255, 100)) : 8'($urandom_range(99, 0));
               bus.req[s] = 1'b1;
               acked[s] = 1'b0;
            end
         end
         rst_n = ($urandom_range(399, 0) != 0);
         if (!rst_n) acked = '0;
         cycle();
      end
      rst_n = 1'b1;
      bus.req = '0;
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
